ram_arbiter_2p: RTL

- Round-robin arbiter sharing one single-port 32x8 RAM between two requesters (requester 0 and requester 1).
- Each requester may hold a burst of back-to-back accesses, bounded by MAX_BURST; ownership then rotates.
- Drives the RAM enable, write-enable, address and write-data pins.
- Routes RAM read data back to the issuing requester with a valid pulse.
- Sits between client engines (for example a pattern writer and a checker) and the RAM IP.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_rd_tag.sv | 28 ++
 rtl/ram_arbiter_2p.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, state encoding and default widths for the two-port RAM arbiter
package ram_arb_pkg;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 8;
  localparam int TAG_VALID_W = 1;
  localparam int TAG_OWNER_W = 1;
  localparam int TAG_W       = TAG_VALID_W + TAG_OWNER_W;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/ram_arb_rd_tag.sv
// ram_arb_rd_tag: RD_LAT-deep {valid, owner} pipeline steering read-data-valid back to the issuer
module ram_arb_rd_tag
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_rvalid0,
  output logic o_rvalid1
);
  logic [RD_LAT-1:0][TAG_W-1:0] r_sr;
  rd_tag_t w_in;
  rd_tag_t w_out;
  assign w_in  = '{valid: i_valid, owner: i_owner};
  assign w_out = rd_tag_t'(r_sr[RD_LAT-1]);
  // shift one tag per RAM cycle; reset discards every in-flight read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sr <= '0;
    else begin
      r_sr[0] <= w_in;
      for (int k = 1; k < RD_LAT; k++) r_sr[k] <= r_sr[k-1];
    end
  assign o_rvalid0 = w_out.valid & ~w_out.owner;
  assign o_rvalid1 = w_out.valid & w_out.owner;
endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: round-robin burst arbiter sharing one single-port RAM; RAM_ARB_STATS_EN adds per-requester beat counters
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
`ifdef RAM_ARB_STATS_EN
  input  logic [DATA_W-1:0] i_ram_rd_data,
  input  logic              i_stats_clr,
  output logic [15:0]       o_cnt0,
  output logic [15:0]       o_cnt1
`else
  input  logic [DATA_W-1:0] i_ram_rd_data
`endif
);
  state_t r_state, w_state_nx;
  logic [3:0] r_beat_cnt, w_beat_cnt_nx;
  logic [4:0] w_beat_inc;
  logic r_last_owner, w_last_owner_nx;
  logic w_own1, w_req_me, w_req_ot, w_accept, w_exit;
  logic r_ram_en, r_ram_we, r_ram_owner;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wr_data;
  // arbitration state, burst length and tie-break history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_beat_cnt   <= w_beat_cnt_nx;
      r_last_owner <= w_last_owner_nx;
    end
  // next owner: hold while the owner requests, rotate at the burst limit only if the other side waits
  always_comb begin
    w_own1          = (r_state == ST_OWN1);
    w_req_me        = w_own1 ? i_req1 : i_req0;
    w_req_ot        = w_own1 ? i_req0 : i_req1;
    w_accept        = (r_state != ST_IDLE) && w_req_me;
    w_beat_inc      = {1'b0, r_beat_cnt} + 5'd1;
    w_exit          = (r_state != ST_IDLE) && (!w_req_me || (w_beat_inc >= 5'(MAX_BURST) && w_req_ot));
    w_state_nx      = r_state;
    w_beat_cnt_nx   = r_beat_cnt;
    w_last_owner_nx = r_last_owner;
    if (r_state == ST_IDLE) begin
      if (i_req0 && (!i_req1 || r_last_owner)) w_state_nx = ST_OWN0;
      else if (i_req1) w_state_nx = ST_OWN1;
    end else if (w_exit) begin
      w_state_nx      = !w_req_ot ? ST_IDLE : (w_own1 ? ST_OWN0 : ST_OWN1);
      w_beat_cnt_nx   = '0;
      w_last_owner_nx = w_own1;
    end else if (w_accept)
      w_beat_cnt_nx = (w_beat_inc >= 5'(MAX_BURST)) ? 4'(MAX_BURST) : w_beat_inc[3:0];
  end
  assign o_gnt0 = (r_state == ST_OWN0) && i_req0;
  assign o_gnt1 = (r_state == ST_OWN1) && i_req1;
  // register the accepted beat onto the RAM pins; address and data hold when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_owner   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wr_data <= '0;
    end else begin
      r_ram_en <= w_accept;
      r_ram_we <= w_accept && (w_own1 ? i_we1 : i_we0);
      if (w_accept) begin
        r_ram_owner   <= w_own1;
        r_ram_addr    <= w_own1 ? i_addr1 : i_addr0;
        r_ram_wr_data <= w_own1 ? i_wdata1 : i_wdata0;
      end
    end
  assign o_ram_en      = r_ram_en;
  assign o_ram_we      = r_ram_we;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_wr_data = r_ram_wr_data;
  assign o_rdata0      = i_ram_rd_data;
  assign o_rdata1      = i_ram_rd_data;
  ram_arb_rd_tag #(.RD_LAT(RD_LAT)) u_rd_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (r_ram_en & ~r_ram_we),
    .i_owner  (r_ram_owner),
    .o_rvalid0(o_rvalid0),
    .o_rvalid1(o_rvalid1)
  );
`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_cnt0, r_cnt1;
  // saturating accepted-beat counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (i_stats_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (o_gnt0 && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if (o_gnt1 && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  assign o_cnt0 = r_cnt0;
  assign o_cnt1 = r_cnt1;
`endif
endmodule
